requant_wb: RTL and testbench

REQUANT_WB -- requirements
Module: requant_wb

---
 rtl/requant_wb_pkg.sv | 22 ++
 rtl/requant_lane.sv | 74 +++++++
 rtl/requant_wb.sv | 134 +++++++++++++
 tb/tb_requant_wb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_wb_pkg.sv
// Shared constants, saturation bounds and FSM state type for the accumulator
// requantise-and-write-back block.
package requant_wb_pkg;

  localparam int LANES   = 16;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 4;
  localparam int COLS    = 64;
  localparam int ADDR_W  = 13;
  localparam int SHIFT_W = 5;

  localparam int SAT_MIN = -8;
  localparam int SAT_MAX = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/requant_lane.sv
// One accumulator lane: stage 1 rounds and arithmetic-shifts, stage 2
// saturates to the INT4 range and holds its value between beats.
module requant_lane
  import requant_wb_pkg::*;
#(
  parameter int ACC_W   = requant_wb_pkg::ACC_W,
  parameter int OUT_W   = requant_wb_pkg::OUT_W,
  parameter int SHIFT_W = requant_wb_pkg::SHIFT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en1,
  input  logic               i_en2,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic [ACC_W-1:0]   i_x,
  output logic [OUT_W-1:0]   o_q
);

  localparam int X_W = ACC_W + 1;
  localparam int S_W = SHIFT_W + 1;
  localparam logic [S_W-1:0]        S_MAX = S_W'(ACC_W);
  localparam logic signed [X_W-1:0] R_HI  = X_W'(SAT_MAX);
  localparam logic signed [X_W-1:0] R_LO  = X_W'(SAT_MIN);

  logic signed [X_W-1:0] x_ext;
  logic signed [X_W-1:0] rnd;
  logic signed [X_W-1:0] sum;
  logic signed [X_W-1:0] shifted;
  logic signed [X_W-1:0] r_d, r_q;
  logic [OUT_W-1:0]      q_d, q_q;

  // One extra bit of headroom keeps x + 2^(s-1) exact for every s <= ACC_W.
  always_comb begin
    x_ext = {i_x[ACC_W-1], i_x};
    rnd   = '0;
    if (i_shift != '0) begin
      rnd = X_W'(1) << (i_shift - SHIFT_W'(1));
    end
    sum     = x_ext + rnd;
    shifted = x_ext;
    if ({1'b0, i_shift} > S_MAX) begin
      shifted = {X_W{i_x[ACC_W-1]}};
    end else if (i_shift != '0) begin
      shifted = sum >>> i_shift;
    end
    r_d = i_en1 ? shifted : r_q;
  end

  always_comb begin
    q_d = q_q;
    if (i_en2) begin
      if (r_q > R_HI) begin
        q_d = R_HI[OUT_W-1:0];
      end else if (r_q < R_LO) begin
        q_d = R_LO[OUT_W-1:0];
      end else begin
        q_d = r_q[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/requant_wb.sv
// Tile write-back controller: accepts COLS accumulator beats, requantises every
// lane to INT4 through a two-stage pipeline and writes one RAM word per beat.
module requant_wb
  import requant_wb_pkg::*;
#(
  parameter int LANES   = requant_wb_pkg::LANES,
  parameter int ACC_W   = requant_wb_pkg::ACC_W,
  parameter int OUT_W   = requant_wb_pkg::OUT_W,
  parameter int COLS    = requant_wb_pkg::COLS,
  parameter int ADDR_W  = requant_wb_pkg::ADDR_W,
  parameter int SHIFT_W = requant_wb_pkg::SHIFT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [SHIFT_W-1:0]     i_cfg_shift,
  input  logic [ADDR_W-1:0]      i_cfg_base,
  input  logic                   i_valid,
  input  logic [LANES*ACC_W-1:0] i_acc_data,
  output logic                   o_ready,
  output logic                   o_ram_we,
  output logic [ADDR_W-1:0]      o_ram_addr,
  output logic [LANES*OUT_W-1:0] o_ram_data,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   col_q, col_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr1_q, addr1_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               v1_q, v1_d;
  logic               we_q, we_d;
  logic               xfer;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    shift_d = shift_q;
    base_d  = base_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          shift_d = i_cfg_shift;
          base_d  = i_cfg_base;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_valid) begin
          xfer = 1'b1;
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = FLUSH;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      // Leave once stage 1 is empty: the final beat then writes in this
      // cycle and o_done lands on the very next one.
      FLUSH: begin
        if (!v1_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    v1_d    = xfer;
    addr1_d = xfer ? (base_q + ADDR_W'(col_q)) : addr1_q;
    we_d    = v1_q;
    addr_d  = v1_q ? addr1_q : addr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      shift_q <= '0;
      base_q  <= '0;
      v1_q    <= 1'b0;
      addr1_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      shift_q <= shift_d;
      base_q  <= base_d;
      v1_q    <= v1_d;
      addr1_q <= addr1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    requant_lane #(
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en1  (xfer),
      .i_en2  (v1_q),
      .i_shift(shift_q),
      .i_x    (i_acc_data[gi*ACC_W +: ACC_W]),
      .o_q    (o_ram_data[gi*OUT_W +: OUT_W])
    );
  end

  assign o_ready    = (state_q == RUN);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_ram_we   = we_q;
  assign o_ram_addr = addr_q;

endmodule

// File: tb/tb_requant_wb.sv
// Bench for requant_wb: table vectors, random tiles against a rule-level model,
// and hand-written gap / wrap / ignored-start / mid-tile reset sequences.
module tb_requant_wb;

  localparam int LANES   = 16;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 4;
  localparam int COLS    = 64;
  localparam int ADDR_W  = 13;
  localparam int SHIFT_W = 5;
  localparam int DW      = LANES * ACC_W;
  localparam int QW      = LANES * OUT_W;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_start = 1'b0;
  logic [SHIFT_W-1:0] i_cfg_shift = '0;
  logic [ADDR_W-1:0]  i_cfg_base = '0;
  logic               i_valid = 1'b0;
  logic [DW-1:0]      i_acc_data = '0;
  logic               o_ready;
  logic               o_ram_we;
  logic [ADDR_W-1:0]  o_ram_addr;
  logic [QW-1:0]      o_ram_data;
  logic               o_busy;
  logic               o_done;

  requant_wb dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_cfg_shift(i_cfg_shift),
    .i_cfg_base (i_cfg_base),
    .i_valid    (i_valid),
    .i_acc_data (i_acc_data),
    .o_ready    (o_ready),
    .o_ram_we   (o_ram_we),
    .o_ram_addr (o_ram_addr),
    .o_ram_data (o_ram_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [QW-1:0]     data;
    int                due;
  } wr_t;

  typedef struct {
    logic [SHIFT_W-1:0] shift;
    logic [ADDR_W-1:0]  base;
    logic [DW-1:0]      x;
    logic [QW-1:0]      exp;
  } vec_t;

  wr_t               exp_q[$];
  vec_t              vt[7];
  logic [DW-1:0]     beat_x[COLS];
  logic [QW-1:0]     beat_e[COLS];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                wr_cnt = 0;
  int                done_cnt = 0;
  int                last_we_cyc = -10;
  int                done_cyc = -10;
  int                mdl_col = 0;
  bit                mdl_run = 1'b0;
  logic [ADDR_W-1:0] tile_base = '0;
  logic [QW-1:0]     cur_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rule-level model: round half up, arithmetic shift, clamp to [-8, 7].
  function automatic logic [OUT_W-1:0] ref_lane(input logic signed [ACC_W-1:0] x, input int s);
    longint v;
    longint r;
    v = longint'(x);
    if (s == 0) r = v;
    else if (s > ACC_W) r = (v < 0) ? -1 : 0;
    else r = (v + (longint'(1) << (s - 1))) >>> s;
    if (r > 7) r = 7;
    else if (r < -8) r = -8;
    return r[OUT_W-1:0];
  endfunction

  function automatic logic [QW-1:0] ref_beat(input logic [DW-1:0] x, input int s);
    logic [QW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[OUT_W*k +: OUT_W] = ref_lane(x[ACC_W*k +: ACC_W], s);
    return r;
  endfunction

  function automatic logic [DW-1:0] mk8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    int a[8];
    int t;
    logic [DW-1:0] r;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    a[4] = a4; a[5] = a5; a[6] = a6; a[7] = a7;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      t = a[k];
      r[ACC_W*k +: ACC_W] = t[ACC_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_all(input int v);
    logic [DW-1:0] r;
    int t;
    t = v;
    for (int k = 0; k < LANES; k++) r[ACC_W*k +: ACC_W] = t[ACC_W-1:0];
    return r;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard: every accepted beat must appear as a write exactly two edges later.
  always @(negedge i_clk) begin
    wr_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got none expected addr %h data %h at cycle %0d", e.addr, e.data, e.due);
    end
    if (o_ram_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write (cycle %0d)", o_ram_addr, o_ram_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(o_ram_addr), 64'(e.addr));
        chk("wr_data", o_ram_data, e.data);
        chk("wr_latency", 64'(cyc), 64'(e.due));
      end
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (i_rst) begin
      exp_q.delete();
    end else if (i_valid && mdl_run && mdl_col < COLS) begin
      e.addr = tile_base + ADDR_W'(mdl_col);
      e.data = cur_exp;
      e.due  = cyc + 2;
      exp_q.push_back(e);
      mdl_col++;
    end
  end

  task automatic start_tile(input logic [SHIFT_W-1:0] sh, input logic [ADDR_W-1:0] base);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_cfg_shift = sh;
    i_cfg_base = base;
    tile_base = base;
    mdl_col = 0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_cfg_shift = '0;
    i_cfg_base = '0;
    mdl_run = 1'b1;
  endtask

  // gap: 0 = back-to-back, 1 = valid toggling 1,0,..., 2 = random valid.
  task automatic run_tile(input logic [SHIFT_W-1:0] sh, input logic [ADDR_W-1:0] base,
                          input int gap, input bit poke);
    int sent;
    int guard;
    int d0;
    int w0;
    bit v;
    sent = 0;
    guard = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    start_tile(sh, base);
    while (sent < COLS && guard < 1000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
      i_valid = v;
      i_acc_data = beat_x[sent];
      cur_exp = beat_e[sent];
      i_start = poke && (sent == 5);
      @(negedge i_clk);
      chk("ready_run", 64'(o_ready), 64'd1);
      @(posedge i_clk); #1;
      if (v) sent++;
      guard++;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    mdl_run = 1'b0;
    if (sent < COLS) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats accepted expected %0d", sent, COLS);
    end
    @(negedge i_clk);
    chk("ready_flush", 64'(o_ready), 64'd0);
    chk("busy_flush", 64'(o_busy), 64'd1);
    for (int k = 0; k < 20 && done_cnt == d0; k++) @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("done_after_last_we", 64'(done_cyc), 64'(last_we_cyc + 1));
    chk("write_count", 64'(wr_cnt - w0), 64'(COLS));
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("busy_idle", 64'(o_busy), 64'd0);
    $display("tile shift=%0d base=%h gap=%0d poke=%0d writes=%0d done=%0d",
             sh, base, gap, poke, wr_cnt - w0, done_cnt - d0);
  endtask

  task automatic load_vec(input int i);
    for (int b = 0; b < COLS; b++) begin
      beat_x[b] = vt[i].x;
      beat_e[b] = vt[i].exp;
    end
  endtask

  task automatic reset_mid_tile();
    int w0;
    int d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    load_vec(0);
    start_tile(5'd4, 13'h080);
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_acc_data = beat_x[k];
      cur_exp = beat_e[k];
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    mdl_run = 1'b0;
    i_rst = 1'b1;
    i_start = 1'b1;
    i_cfg_base = 13'h1AA;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_start = 1'b0;
    i_cfg_base = '0;
    @(negedge i_clk);
    chk("rst_mid_ready", 64'(o_ready), 64'd0);
    chk("rst_mid_we", 64'(o_ram_we), 64'd0);
    chk("rst_mid_addr", 64'(o_ram_addr), 64'd0);
    chk("rst_mid_data", o_ram_data, 64'd0);
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_done", 64'(o_done), 64'd0);
    repeat (10) @(negedge i_clk);
    chk("rst_mid_writes", 64'(wr_cnt - w0), 64'd9);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    $display("reset mid-tile: writes before reset=%0d done=%0d", wr_cnt - w0, done_cnt - d0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SHIFT_W-1:0] sh;
    int v;
    int t;
    vt[0] = '{5'd4,  13'h0100, mk_all(53), 64'h3333333333333333};
    vt[1] = '{5'd0,  13'h0200, mk8(100, -100, -8, 0, 0, 0, 0, 0), 64'h0000000000000887};
    vt[2] = '{5'd1,  13'h0300, mk8(0, 0, 0, -3, 0, 0, 0, 0), 64'h000000000000F000};
    vt[3] = '{5'd3,  13'h0400, mk8(4, 3, -4, -5, 60, 59, -68, -69), 64'h000000008877F001};
    vt[4] = '{5'd23, 13'h0500, mk8(8388607, -8388608, 4194303, 0, 0, 0, 0, 0), 64'h00000000000000F1};
    vt[5] = '{5'd25, 13'h0600, mk8(-5, 5, -8388608, 8388607, 0, 0, 0, 0), 64'h0000000000000F0F};
    vt[6] = '{5'd2,  13'h1FF0, mk_all(-6), 64'hFFFFFFFFFFFFFFFF};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_we", 64'(o_ram_we), 64'd0);
    chk("rst_addr", 64'(o_ram_addr), 64'd0);
    chk("rst_data", o_ram_data, 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_vec(i);
      run_tile(vt[i].shift, vt[i].base, 0, 1'b0);
    end

    load_vec(0);
    run_tile(5'd4, 13'h0040, 1, 1'b0);

    load_vec(3);
    run_tile(5'd3, 13'h0123, 0, 1'b1);

    reset_mid_tile();
    load_vec(0);
    run_tile(5'd4, 13'h0010, 0, 1'b0);

    for (int n = 0; n < 3; n++) begin
      sh = SHIFT_W'($urandom_range(0, 31));
      for (int b = 0; b < COLS; b++) begin
        for (int k = 0; k < LANES; k++) begin
          case ($urandom_range(0, 3))
            0: v = int'($urandom);
            1: v = int'($urandom_range(0, 400)) - 200;
            2: v = ($urandom_range(0, 1) == 1) ? 8388607 : -8388608;
            default: v = int'($urandom_range(0, 40)) - 20;
          endcase
          t = v;
          beat_x[b][ACC_W*k +: ACC_W] = t[ACC_W-1:0];
        end
        beat_e[b] = ref_beat(beat_x[b], int'(sh));
      end
      run_tile(sh, ADDR_W'($urandom), 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
